spi_slave: RTL and testbench

- SPI responder (slave) for the team's SPI master; mode 0 only (CPOL=0, CPHA=0), MSB first.
- Oversamples the external SPI pins in the system clock domain.
- Deserializes MOSI into words and serializes MISO from a single-entry transmit buffer fed by a valid/ready handshake.
- Sits at the chip boundary, on the peripheral side of an SPI link.

---
 rtl/spi_slave.sv | 160 ++++++++++++++++
 tb/tb_spi_slave.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples the SPI pins in clk_i and deserializes MOSI into words.
// MISO is fed from a single-entry transmit buffer.
`timescale 1ns/1ps
module spi_slave #(
    parameter int                    WORD_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [WORD_WIDTH-1:0] FILL_WORD   = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sclk_i,
    input  logic                  ss_ni,
    input  logic                  mosi_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    input  logic [WORD_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [WORD_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  underrun_o,
    output logic                  busy_o
);

    localparam int CNT_W = (WORD_WIDTH > 2) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  sclk_sync, ss_sync, mosi_sync;
    logic                    sclk_d, ss_d;
    logic                    rise, fall, ss_fall, ss_rise, mosi_s;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    load_pend, rx_done, do_load;
    logic [WORD_WIDTH-1:0]   rx_shift, tx_buf;
    logic [WORD_WIDTH-2:0]   tx_rest;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_ni};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ss_d      <= ss_sync[SYNC_STAGES-1];
        end
    end

    // A deselect wins over any coincident sclk edge, so a master that drops sclk
    // together with raising ss_n ends the transfer without loading another word.
    always_comb begin
        rise    = sclk_sync[SYNC_STAGES-1] & ~sclk_d;
        fall    = ~sclk_sync[SYNC_STAGES-1] & sclk_d;
        ss_fall = ~ss_sync[SYNC_STAGES-1] & ss_d;
        ss_rise = ss_sync[SYNC_STAGES-1] & ~ss_d;
        mosi_s  = mosi_sync[SYNC_STAGES-1];
        do_load = 1'b0;
        if (state == IDLE)
            do_load = ss_fall;
        else if (!ss_rise)
            do_load = fall & load_pend;
    end

    // Transmit handshake: a word is accepted on any clk_i edge where tx_valid_i
    // and tx_ready_o are both high; tx_ready_o stays low until a word load
    // moves the buffered word into the shifter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            load_pend  <= 1'b0;
            rx_done    <= 1'b0;
            rx_shift   <= '0;
            tx_buf     <= '0;
            tx_rest    <= '0;
            miso_o     <= 1'b0;
            miso_oe_o  <= 1'b0;
            tx_ready_o <= 1'b1;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            underrun_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            underrun_o <= 1'b0;
            rx_done    <= 1'b0;
            if (rx_done) begin
                rx_data_o  <= rx_shift;
                rx_valid_o <= 1'b1;
            end

            if (tx_valid_i && tx_ready_o) begin
                tx_buf     <= tx_data_i;
                tx_ready_o <= 1'b0;
            end

            if (do_load) begin
                if (!tx_ready_o) begin
                    miso_o     <= tx_buf[WORD_WIDTH-1];
                    tx_rest    <= tx_buf[WORD_WIDTH-2:0];
                    tx_ready_o <= 1'b1;
                end else begin
                    miso_o     <= FILL_WORD[WORD_WIDTH-1];
                    tx_rest    <= FILL_WORD[WORD_WIDTH-2:0];
                    underrun_o <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state     <= ACTIVE;
                        bit_cnt   <= '0;
                        load_pend <= 1'b0;
                        miso_oe_o <= 1'b1;
                        busy_o    <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (ss_rise) begin
                        state     <= IDLE;
                        bit_cnt   <= '0;
                        load_pend <= 1'b0;
                        rx_shift  <= '0;
                        miso_oe_o <= 1'b0;
                        miso_o    <= 1'b0;
                        busy_o    <= 1'b0;
                    end else begin
                        if (rise) begin
                            rx_shift <= {rx_shift[WORD_WIDTH-2:0], mosi_s};
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt   <= '0;
                                load_pend <= 1'b1;
                                rx_done   <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                        if (fall) begin
                            if (load_pend) begin
                                load_pend <= 1'b0;
                            end else if (bit_cnt != '0) begin
                                miso_o  <= tx_rest[WORD_WIDTH-2];
                                tx_rest <= tx_rest << 1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a mode-0 master model drives the pins and
// received words are scored against an expected queue.
`timescale 1ns/1ps
module tb_spi_slave;

    localparam int W    = 8;
    localparam int HALF = 80;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         sclk_i = 1'b0;
    logic         ss_ni = 1'b1;
    logic         mosi_i = 1'b0;
    logic         miso_o, miso_oe_o;
    logic [W-1:0] tx_data_i = '0;
    logic         tx_valid_i = 1'b0;
    logic         tx_ready_o;
    logic [W-1:0] rx_data_o;
    logic         rx_valid_o, underrun_o, busy_o;

    int total = 0;
    int bad   = 0;
    int rx_cnt = 0;
    int unr_cnt = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got;

    spi_slave #(.WORD_WIDTH(W), .SYNC_STAGES(2), .FILL_WORD(8'h00)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .sclk_i(sclk_i), .ss_ni(ss_ni),
        .mosi_i(mosi_i), .miso_o(miso_o), .miso_oe_o(miso_oe_o),
        .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .underrun_o(underrun_o),
        .busy_o(busy_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard
    initial forever begin
        @(negedge clk_i);
        if (rst_ni) begin
            if (rx_valid_o) begin
                rx_cnt++;
                if (exp_q.size() == 0) check("rx_unexpected", {24'h0, rx_data_o}, 32'hffff_ffff);
                else check("rx_data", {24'h0, rx_data_o}, {24'h0, exp_q.pop_front()});
            end
            if (underrun_o) unr_cnt++;
        end
    end

    // drivers
    task automatic tx_write(input logic [W-1:0] d);
        int n = 0;
        @(negedge clk_i);
        while (!tx_ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("tx_ready_wait", {31'h0, tx_ready_o}, 32'h1);
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        @(posedge clk_i);
        #1 tx_valid_i = 1'b0;
        check("tx_ready_drop", {31'h0, tx_ready_o}, 32'h0);
    endtask

    task automatic spi_select();
        @(negedge clk_i);
        ss_ni = 1'b0;
        #(HALF);
    endtask

    // MSB-first bits; on the last bit of a transfer sclk falls as ss_n rises
    task automatic spi_bits(input logic [W-1:0] data, input int nbits, input bit last,
                            output logic [W-1:0] rd);
        rd = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi_i = data[W-1-i];
            #(HALF);
            sclk_i = 1'b1;
            rd = {rd[W-2:0], miso_o};
            #(HALF);
            sclk_i = 1'b0;
            if (last && i == nbits - 1) ss_ni = 1'b1;
        end
    endtask

    task automatic settle();
        repeat (8) @(negedge clk_i);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        check("rst_miso", {31'h0, miso_o}, 32'h0);
        check("rst_oe", {31'h0, miso_oe_o}, 32'h0);
        check("rst_ready", {31'h0, tx_ready_o}, 32'h1);
        check("rst_rx_data", {24'h0, rx_data_o}, 32'h0);
        check("rst_busy", {31'h0, busy_o}, 32'h0);
        rst_ni = 1'b1;
        settle();

        // single word
        rx_cnt = 0; unr_cnt = 0;
        tx_write(8'hA5);
        exp_q.push_back(8'h3C);
        spi_select();
        check("t1_busy", {31'h0, busy_o}, 32'h1);
        check("t1_oe", {31'h0, miso_oe_o}, 32'h1);
        check("t1_ready_after_load", {31'h0, tx_ready_o}, 32'h1);
        spi_bits(8'h3C, 8, 1'b1, got);
        check("t1_miso", {24'h0, got}, 32'hA5);
        settle();
        check("t1_rx_pulses", rx_cnt, 1);
        check("t1_underruns", unr_cnt, 0);
        check("t1_oe_idle", {31'h0, miso_oe_o}, 32'h0);
        check("t1_busy_idle", {31'h0, busy_o}, 32'h0);

        // back-to-back words in one select
        rx_cnt = 0; unr_cnt = 0;
        tx_write(8'h11);
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h0F);
        spi_select();
        tx_write(8'h22);
        spi_bits(8'hF0, 8, 1'b0, got);
        check("t2_miso0", {24'h0, got}, 32'h11);
        spi_bits(8'h0F, 8, 1'b1, got);
        check("t2_miso1", {24'h0, got}, 32'h22);
        settle();
        check("t2_rx_pulses", rx_cnt, 2);
        check("t2_underruns", unr_cnt, 0);

        // underrun
        rx_cnt = 0; unr_cnt = 0;
        exp_q.push_back(8'h81);
        spi_select();
        spi_bits(8'h81, 8, 1'b1, got);
        check("t3_miso_fill", {24'h0, got}, 32'h00);
        settle();
        check("t3_underruns", unr_cnt, 1);
        check("t3_rx_pulses", rx_cnt, 1);
        check("t3_rx_data", {24'h0, rx_data_o}, 32'h81);

        // abort mid-word, then a clean word
        rx_cnt = 0;
        spi_select();
        spi_bits(8'hFF, 5, 1'b1, got);
        settle();
        check("t4_no_rx", rx_cnt, 0);
        check("t4_oe", {31'h0, miso_oe_o}, 32'h0);
        check("t4_busy", {31'h0, busy_o}, 32'h0);
        check("t4_miso", {31'h0, miso_o}, 32'h0);
        exp_q.push_back(8'h5A);
        spi_select();
        spi_bits(8'h5A, 8, 1'b1, got);
        settle();
        check("t4_rx_pulses", rx_cnt, 1);
        check("t4_rx_data", {24'h0, rx_data_o}, 32'h5A);

        // reset mid-word
        tx_write(8'h99);
        spi_select();
        tx_write(8'h66);
        spi_bits(8'hE0, 3, 1'b0, got);
        rst_ni = 1'b0;
        #1;
        check("t5_miso", {31'h0, miso_o}, 32'h0);
        check("t5_oe", {31'h0, miso_oe_o}, 32'h0);
        check("t5_ready", {31'h0, tx_ready_o}, 32'h1);
        check("t5_rx_data", {24'h0, rx_data_o}, 32'h0);
        check("t5_rx_valid", {31'h0, rx_valid_o}, 32'h0);
        check("t5_underrun", {31'h0, underrun_o}, 32'h0);
        check("t5_busy", {31'h0, busy_o}, 32'h0);
        ss_ni = 1'b1;
        #(HALF);
        rst_ni = 1'b1;
        settle();
        rx_cnt = 0;
        exp_q.push_back(8'hC3);
        spi_select();
        spi_bits(8'hC3, 8, 1'b1, got);
        check("t5_miso_fill", {24'h0, got}, 32'h00);
        settle();
        check("t5_rx_pulses", rx_cnt, 1);

        // write coincident with the select-time load
        rx_cnt = 0; unr_cnt = 0;
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        @(negedge clk_i);
        ss_ni = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        tx_data_i  = 8'h77;
        tx_valid_i = 1'b1;
        @(posedge clk_i);
        #1 tx_valid_i = 1'b0;
        check("t6_underrun_pulse", {31'h0, underrun_o}, 32'h1);
        check("t6_buffer_full", {31'h0, tx_ready_o}, 32'h0);
        check("t6_busy", {31'h0, busy_o}, 32'h1);
        spi_bits(8'h12, 8, 1'b0, got);
        check("t6_miso0", {24'h0, got}, 32'h00);
        spi_bits(8'h34, 8, 1'b1, got);
        check("t6_miso1", {24'h0, got}, 32'h77);
        settle();
        check("t6_underruns", unr_cnt, 1);
        check("t6_rx_pulses", rx_cnt, 2);

        check("exp_q_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
